// File: rtl/ack_bus_requester_if.sv
// Requester <-> ACK arbiter bus: request out, one-hot grant plus the broadcast winner/event in.
// A grant is only valid when ack_ready, ack_event and a matching winner ID arrive together while req is high.
interface ack_bus_requester_if;
  logic       req;
  logic       ack_ready;
  logic [1:0] winner_source_id;
  logic       ack_event;

  modport master (
    output req,
    input  ack_ready,
    input  winner_source_id,
    input  ack_event
  );

  modport slave (
    input  req,
    output ack_ready,
    output winner_source_id,
    output ack_event
  );
endinterface

// File: rtl/ack_bus_requester.sv
// Module-side ACK bus client: counts owed acks, requests the bus until granted,
// forces a one-cycle release gap after each grant and raises sticky error flags.
module ack_bus_requester #(
  parameter logic [1:0] SRC_ID         = 2'b00,
  parameter int         DEPTH          = 4,
  parameter int         TIMEOUT_CYCLES = 16,
  localparam int        CW             = $clog2(DEPTH + 1),
  localparam int        TW             = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_i,
  input  logic                       clear_i,
  ack_bus_requester_if.master        bus,
  output logic [CW-1:0]              pending_o,
  output logic                       granted_o,
  output logic                       overflow_o,
  output logic                       timeout_o,
  output logic                       proto_err_o,
  output logic [1:0]                 dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          granted_q, overflow_q, timeout_q, proto_q;
  logic          overflow_d, timeout_d, proto_d;

  logic in_req, id_match, grant, proto_viol, full, inc, ovf_set, to_set;

  always_comb begin
    in_req     = (state_q == ST_REQ);
    id_match   = bus.ack_event && (bus.winner_source_id == SRC_ID);
    grant      = in_req && bus.ack_ready && id_match;
    // A violating cycle never counts as a grant: grant already requires all three to agree.
    proto_viol = (bus.ack_ready && !in_req) ||
                 (in_req && bus.ack_ready && !id_match) ||
                 (in_req && id_match && !bus.ack_ready);
    full       = (pending_q == CW'(DEPTH));
    inc        = done_i && !(full && !grant);
    ovf_set    = done_i && full && !grant;

    pending_d = pending_q;
    if (inc && !grant) begin
      pending_d = pending_q + CW'(1);
    end else if (!inc && grant) begin
      pending_d = pending_q - CW'(1);
    end

    wait_d = '0;
    to_set = 1'b0;
    if (in_req && !grant) begin
      wait_d = (wait_q == TW'(TIMEOUT_CYCLES)) ? wait_q : wait_q + TW'(1);
      to_set = (TIMEOUT_CYCLES != 0) && (wait_d == TW'(TIMEOUT_CYCLES));
    end

    // Same-cycle set beats clear so no event is lost.
    overflow_d = ovf_set    || (overflow_q && !clear_i);
    timeout_d  = to_set     || (timeout_q  && !clear_i);
    proto_d    = proto_viol || (proto_q    && !clear_i);

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pending_d != '0) state_d = ST_REQ;
      ST_REQ:  if (grant)           state_d = ST_GAP;
      ST_GAP:  state_d = (pending_d != '0) ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      wait_q     <= '0;
      granted_q  <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wait_q     <= wait_d;
      granted_q  <= grant;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      proto_q    <= proto_d;
    end
  end

  assign bus.req     = (state_q == ST_REQ);
  assign pending_o   = pending_q;
  assign granted_o   = granted_q;
  assign overflow_o  = overflow_q;
  assign timeout_o   = timeout_q;
  assign proto_err_o = proto_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ack_bus_requester.sv
// Directed bench for ack_bus_requester: a rule-level model checked every cycle
// plus hand-computed literal expectations at the key points of each scenario.
module tb_ack_bus_requester;
  localparam logic [1:0] ID    = 2'b00;
  localparam int         DEPTH = 4;
  localparam int         TMO   = 16;
  localparam int         CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          done = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] pending;
  logic          granted, ovf, tmo, perr;
  logic [1:0]    dbg_state;

  ack_bus_requester_if bus ();

  ack_bus_requester #(.SRC_ID(ID), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .done_i      (done),
    .clear_i     (clr),
    .bus         (bus),
    .pending_o   (pending),
    .granted_o   (granted),
    .overflow_o  (ovf),
    .timeout_o   (tmo),
    .proto_err_o (perr),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Request rule: after any edge, req is high iff acks are still owed and that edge was not a grant.
  int m_pend, m_wait;
  bit m_req, m_gnt, m_ovf, m_to, m_pe;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0; m_wait = 0;
      m_req = 0; m_gnt = 0; m_ovf = 0; m_to = 0; m_pe = 0;
    end else begin
      bit g, viol, ovf_set, to_set, idm;
      idm  = bus.ack_event && (bus.winner_source_id == ID);
      g    = m_req && bus.ack_ready && idm;
      viol = (bus.ack_ready && !m_req) || (m_req && bus.ack_ready && !idm) ||
             (m_req && idm && !bus.ack_ready);
      ovf_set = 0;
      if (done) begin
        if (m_pend < DEPTH || g) m_pend = m_pend + 1;
        else ovf_set = 1;
      end
      if (g) m_pend = m_pend - 1;
      if (m_req && !g) m_wait = (m_wait + 1 > TMO) ? TMO : m_wait + 1;
      else m_wait = 0;
      to_set = (TMO != 0) && m_req && !g && (m_wait == TMO);
      m_ovf = ovf_set || (m_ovf && !clr);
      m_to  = to_set  || (m_to  && !clr);
      m_pe  = viol    || (m_pe  && !clr);
      m_gnt = g;
      m_req = (m_pend != 0) && !g;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_req",      bus.req,  m_req);
      check("m_pending",  pending,  m_pend);
      check("m_granted",  granted,  m_gnt);
      check("m_overflow", ovf,      m_ovf);
      check("m_timeout",  tmo,      m_to);
      check("m_proto",    perr,     m_pe);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic bus_cycle(input logic [1:0] win, input logic ar, input logic ae);
    bus.winner_source_id = win;
    bus.ack_ready        = ar;
    bus.ack_event        = ae;
    tick();
    bus.winner_source_id = 2'b00;
    bus.ack_ready        = 1'b0;
    bus.ack_event        = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pending != 0; i++) begin
      if (bus.req) bus_cycle(ID, 1'b1, 1'b1);
      else tick();
    end
    check("drain_empty", pending, 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.ack_ready        = 1'b0;
    bus.ack_event        = 1'b0;
    bus.winner_source_id = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",     bus.req, 0);
    check("rst_pending", pending, 0);
    check("rst_flags",   {granted, ovf, tmo, perr}, 0);
    rst = 1'b0;
    tick();

    // 1: single ack, grant in cycle 3
    pulse_done();
    check("t1_req_c1",  bus.req, 1);
    check("t1_pend_c1", pending, 1);
    tick();
    tick();
    bus_cycle(ID, 1'b1, 1'b1);
    check("t1_granted_c4", granted, 1);
    check("t1_req_gap",    bus.req, 0);
    check("t1_pend_c4",    pending, 0);
    tick();
    check("t1_req_idle",   bus.req, 0);
    check("t1_granted_c5", granted, 0);

    // 2: three acks, grant every REQ cycle -> req 1,0,1,0,1,0
    pulse_done(); pulse_done(); pulse_done();
    check("t2_pend3", pending, 3);
    for (int k = 2; k >= 0; k--) begin
      check("t2_req_hi", bus.req, 1);
      bus_cycle(ID, 1'b1, 1'b1);
      check("t2_req_lo", bus.req, 0);
      check("t2_pend",   pending, k);
      tick();
    end
    check("t2_req_end", bus.req, 0);
    check("t2_flags",   {ovf, tmo, perr}, 0);

    // 3: overflow at DEPTH, clear, same-cycle set beats clear
    repeat (5) pulse_done();
    check("t3_pend_full", pending, 4);
    check("t3_ovf_set",   ovf, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t3_ovf_clr",   ovf, 0);
    check("t3_pend_keep", pending, 4);
    clr = 1'b1; done = 1'b1; tick(); clr = 1'b0; done = 1'b0;
    check("t3_set_wins",  ovf, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t3_ovf_clr2",  ovf, 0);
    drain();

    // 4: done and grant in the same cycle keep pending
    pulse_done(); pulse_done();
    done = 1'b1;
    bus_cycle(ID, 1'b1, 1'b1);
    done = 1'b0;
    check("t4_pend_same", pending, 2);
    check("t4_req_gap",   bus.req, 0);
    check("t4_granted",   granted, 1);
    tick();
    check("t4_req_again", bus.req, 1);
    drain();

    // 5: starvation timeout after 16 REQ cycles
    pulse_done();
    repeat (15) tick();
    check("t5_tmo_before", tmo, 0);
    tick();
    check("t5_tmo_set",    tmo, 1);
    check("t5_req_kept",   bus.req, 1);
    bus_cycle(ID, 1'b1, 1'b1);
    check("t5_pend_dec",   pending, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t5_tmo_clr",    tmo, 0);

    // 6: wrong winner is a protocol error, not a grant; async reset mid-REQ
    pulse_done();
    bus_cycle(ID ^ 2'b01, 1'b1, 1'b1);
    check("t6_proto",      perr, 1);
    check("t6_pend_keep",  pending, 1);
    check("t6_no_grant",   granted, 0);
    check("t6_req_kept",   bus.req, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t6_proto_clr",  perr, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_req",    bus.req, 0);
    check("t6_rst_pend",   pending, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_rst",   bus.req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
